// File: rtl/mem_test_sequencer.sv
// rtl/mem_test_sequencer.sv - write/readback memory self-test initiator with pass/fail, error count and first fail address
// Optional second inverted-data pass is enabled by defining MEM_TEST_INVERT_PASS_EN.
module mem_test_sequencer #(
  parameter int          MEM_WIDTH    = 32,
  parameter int          MEM_SIZE     = 256,
  parameter int          ADDR_WIDTH   = 8,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] SEED         = 32'hA5A5_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [MEM_WIDTH-1:0]  data_write,
  output logic                  write_en,
  output logic                  read_en,
  input  logic [MEM_WIDTH-1:0]  data_read,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_DONE
  } state_t;

  localparam int                    CNT_W     = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0]      LAT       = CNT_W'(READ_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [MEM_WIDTH-1:0]  SEED_W    = MEM_WIDTH'(SEED);

  function automatic logic [MEM_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a, input logic inv);
    logic [MEM_WIDTH-1:0] v;
    v = SEED_W ^ MEM_WIDTH'(a);
    return inv ? ~v : v;
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   a_q, a_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    first_err_q, first_err_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [MEM_WIDTH-1:0]    data_write_q, data_write_d;
  logic                    write_en_q, write_en_d;
  logic                    read_en_q, read_en_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [15:0]             err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic                    cur_inv;

`ifdef MEM_TEST_INVERT_PASS_EN
  logic p_q, p_d;
  assign cur_inv = p_q;
`else
  assign cur_inv = 1'b0;
`endif

  // Outputs are registered, so each branch computes what the next cycle shows.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    cnt_d        = cnt_q;
    first_err_d  = first_err_q;
    addr_d       = addr_q;
    data_write_d = data_write_q;
    write_en_d   = 1'b0;
    read_en_d    = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    fail_addr_d  = fail_addr_q;
`ifdef MEM_TEST_INVERT_PASS_EN
    p_d          = p_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_WRITE;
          a_d          = '0;
          first_err_d  = 1'b0;
          err_count_d  = '0;
          fail_addr_d  = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          write_en_d   = 1'b1;
          addr_d       = '0;
          data_write_d = pattern('0, 1'b0);
`ifdef MEM_TEST_INVERT_PASS_EN
          p_d          = 1'b0;
`endif
        end
      end

      S_WRITE: begin
        if (a_q == LAST_ADDR) begin
          state_d   = S_RD_ISSUE;
          a_d       = '0;
          read_en_d = 1'b1;
          addr_d    = '0;
        end else begin
          a_d          = a_q + ADDR_WIDTH'(1);
          write_en_d   = 1'b1;
          addr_d       = a_q + ADDR_WIDTH'(1);
          data_write_d = pattern(a_q + ADDR_WIDTH'(1), cur_inv);
        end
      end

      S_RD_ISSUE: begin
        state_d = S_RD_WAIT;
        cnt_d   = CNT_W'(1);
      end

      S_RD_WAIT: begin
        if (cnt_q == LAT) begin
          if (data_read != pattern(a_q, cur_inv)) begin
            if (err_count_q != 16'hFFFF) begin
              err_count_d = err_count_q + 16'd1;
            end
            if (!first_err_q) begin
              first_err_d = 1'b1;
              fail_addr_d = a_q;
            end
          end
          if (a_q == LAST_ADDR) begin
`ifdef MEM_TEST_INVERT_PASS_EN
            if (!p_q) begin
              p_d          = 1'b1;
              a_d          = '0;
              state_d      = S_WRITE;
              write_en_d   = 1'b1;
              addr_d       = '0;
              data_write_d = pattern('0, 1'b1);
            end else begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_count_d == 16'd0);
            end
`else
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == 16'd0);
`endif
          end else begin
            a_d       = a_q + ADDR_WIDTH'(1);
            state_d   = S_RD_ISSUE;
            read_en_d = 1'b1;
            addr_d    = a_q + ADDR_WIDTH'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      cnt_q        <= '0;
      first_err_q  <= 1'b0;
      addr_q       <= '0;
      data_write_q <= '0;
      write_en_q   <= 1'b0;
      read_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= '0;
      fail_addr_q  <= '0;
`ifdef MEM_TEST_INVERT_PASS_EN
      p_q          <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      cnt_q        <= cnt_d;
      first_err_q  <= first_err_d;
      addr_q       <= addr_d;
      data_write_q <= data_write_d;
      write_en_q   <= write_en_d;
      read_en_q    <= read_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      fail_addr_q  <= fail_addr_d;
`ifdef MEM_TEST_INVERT_PASS_EN
      p_q          <= p_d;
`endif
    end
  end

  assign addr       = addr_q;
  assign data_write = data_write_q;
  assign write_en   = write_en_q;
  assign read_en    = read_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_addr  = fail_addr_q;

endmodule
